generador_pwm: RTL and testbench

GENERADOR_PWM -- requirements
Module: generador_pwm

---
 rtl/generador_pwm.sv | 139 +++++++++++++
 tb/tb_generador_pwm.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/generador_pwm.sv
// Prescaled PWM generator with a shadowed duty cycle, input saturation flag
// and a missing-sample timeout that parks the output in a FAULT state.
module generador_pwm #(
  parameter int unsigned PRE_DIV     = 4,
  parameter int unsigned PERIOD      = 500,
  parameter int unsigned TIMEOUT_PER = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] PWMin,
  input  logic        ena2,
  output logic        pwm,
  output logic        period_tick,
  output logic        sat,
  output logic        fault
);

  localparam int unsigned PCNT_W = 8;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned MISS_W = 8;

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRE_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  DUTY_MAX  = CNT_W'(PERIOD);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(TIMEOUT_PER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FAULT
  } state_e;

  state_e              state_q;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    shadow_q;
  logic [CNT_W-1:0]    duty_q;
  logic [MISS_W-1:0]   miss_q;
  logic                got_q;

  logic                tick;
  logic                boundary;
  logic                boundary_next;
  logic                sample_seen;
  logic [CNT_W-1:0]    duty_in;
  logic                clamped;

  // Free-running timebase and input clamp
  always_comb begin
    tick          = (pcnt_q == PCNT_LAST);
    boundary      = tick && (cnt_q == CNT_LAST);
    pcnt_d        = tick ? '0 : pcnt_q + PCNT_W'(1);
    cnt_d         = cnt_q;
    if (tick) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
    // period_tick is registered, so it is computed from the next counter state
    boundary_next = (pcnt_d == PCNT_LAST) && (cnt_d == CNT_LAST);
    sample_seen   = got_q || ena2;

    duty_in = PWMin[CNT_W-1:0];
    clamped = 1'b0;
    if (PWMin[17]) begin
      duty_in = '0;
      clamped = 1'b1;
    end else if (PWMin[16:0] >= 17'(PERIOD)) begin
      duty_in = DUTY_MAX;
      clamped = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pcnt_q      <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      duty_q      <= '0;
      miss_q      <= '0;
      got_q       <= 1'b0;
      pwm         <= 1'b0;
      period_tick <= 1'b0;
      sat         <= 1'b0;
      fault       <= 1'b0;
    end else begin
      pcnt_q      <= pcnt_d;
      cnt_q       <= cnt_d;
      period_tick <= boundary_next;
      pwm         <= (state_q == S_RUN) && (cnt_q < duty_q);

      if (ena2) begin
        shadow_q <= duty_in;
        sat      <= clamped;
      end

      // duty_act only moves at the boundary, always from the pre-update shadow
      if (boundary) begin
        duty_q <= shadow_q;
        got_q  <= 1'b0;
      end else if (ena2) begin
        got_q  <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (boundary && sample_seen) begin
            state_q <= S_RUN;
            miss_q  <= '0;
          end
        end
        S_RUN: begin
          if (ena2 || (boundary && got_q)) begin
            miss_q <= '0;
          end else if (boundary) begin
            if (miss_q >= MISS_LAST) begin
              state_q <= S_FAULT;
              fault   <= 1'b1;
              miss_q  <= '0;
            end else begin
              miss_q <= miss_q + MISS_W'(1);
            end
          end
        end
        S_FAULT: begin
          if (boundary && sample_seen) begin
            state_q <= S_RUN;
            fault   <= 1'b0;
            miss_q  <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          fault   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_generador_pwm.sv
// Bench for generador_pwm: directed scenarios plus random samples, all
// cycles compared against a time-indexed behavioural model.
module tb_generador_pwm;

  localparam int PRE_DIV     = 4;
  localparam int PERIOD      = 500;
  localparam int TIMEOUT_PER = 8;
  localparam int TOT         = PRE_DIV * PERIOD;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FAULT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] PWMin = '0;
  logic        ena2 = 1'b0;
  logic        pwm, period_tick, sat, fault;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: k counts clocks since reset release
  int k = 0;
  int m_st = M_IDLE;
  int m_shadow = 0, m_duty = 0, m_miss = 0;
  bit m_got = 0, m_pwm = 0, m_tick = 0, m_sat = 0, m_fault = 0;

  generador_pwm #(
    .PRE_DIV(PRE_DIV),
    .PERIOD(PERIOD),
    .TIMEOUT_PER(TIMEOUT_PER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .PWMin(PWMin),
    .ena2(ena2),
    .pwm(pwm),
    .period_tick(period_tick),
    .sat(sat),
    .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
  endtask

  function automatic int cur_pos();
    return k % TOT;
  endfunction

  function automatic logic [17:0] rnd();
    return 18'($urandom);
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [17:0] v);
    int pos, cntv, sv;
    bit bnd, sample;
    if (r) begin
      k = 0; m_st = M_IDLE; m_shadow = 0; m_duty = 0; m_miss = 0;
      m_got = 0; m_pwm = 0; m_tick = 0; m_sat = 0; m_fault = 0;
      return;
    end
    pos    = k % TOT;
    bnd    = (pos == TOT - 1);
    cntv   = pos / PRE_DIV;
    m_pwm  = (m_st == M_RUN) && (cntv < m_duty);
    sample = m_got || e;
    if (bnd) begin
      if (m_st == M_RUN) begin
        if (sample) m_miss = 0;
        else if (m_miss + 1 >= TIMEOUT_PER) begin
          m_st = M_FAULT;
          m_miss = 0;
        end else m_miss++;
      end else if (sample) begin
        m_st = M_RUN;
        m_miss = 0;
      end
      m_duty = m_shadow;
      m_got  = 0;
    end else if (e) m_got = 1;
    if (e) begin
      sv = $signed(v);
      if (sv < 0) begin m_shadow = 0; m_sat = 1; end
      else if (sv >= PERIOD) begin m_shadow = PERIOD; m_sat = 1; end
      else begin m_shadow = sv; m_sat = 0; end
    end
    k++;
    m_tick  = ((k % TOT) == TOT - 1);
    m_fault = (m_st == M_FAULT);
  endtask

  // Drive inputs for the current cycle, clock, then compare the new cycle
  task automatic cyc(input logic r, input logic e, input logic [17:0] v);
    rst = r; ena2 = e; PWMin = v;
    @(posedge clk);
    model_step(r, e, v);
    @(negedge clk);
    check("pwm", int'(pwm), int'(m_pwm));
    check("period_tick", int'(period_tick), int'(m_tick));
    check("sat", int'(sat), int'(m_sat));
    check("fault", int'(fault), int'(m_fault));
  endtask

  task automatic run_to_pos(input int p);
    int guard = 0;
    while (cur_pos() != p && guard < 2 * TOT) begin
      cyc(1'b0, 1'b0, rnd());
      guard++;
    end
    check("run_to_pos_bound", int'(guard < 2 * TOT), 1);
  endtask

  task automatic next_period();
    cyc(1'b0, 1'b0, rnd());
    run_to_pos(0);
  endtask

  // Counts pwm highs over one period starting at position 0 (one-clock latency)
  task automatic measure(input string tag, input int exp);
    int hi = 0;
    for (int i = 0; i < TOT; i++) begin
      cyc(1'b0, 1'b0, rnd());
      if (pwm) hi++;
    end
    check(tag, hi, exp);
  endtask

  int tbl_val[4] = '{-5, 600, 499, 500};
  int tbl_sat[4] = '{1, 1, 0, 1};
  int tbl_hi[4]  = '{0, 2000, 1996, 2000};

  initial begin
    int n;
    logic [17:0] v;
    @(negedge clk);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 18'd123);
    cyc(1'b1, 1'b0, '0);
    check("rst_pwm", int'(pwm), 0);
    check("rst_tick", int'(period_tick), 0);
    check("rst_sat", int'(sat), 0);
    check("rst_fault", int'(fault), 0);

    // First sample at clock 10, RUN from the first boundary
    run_to_pos(10);
    cyc(1'b0, 1'b1, 18'd250);
    run_to_pos(0);
    check("first_tick_seen", int'(period_tick), 0);
    measure("hi_250", 1000);
    check("sat_250", int'(sat), 0);

    // Sample coincident with the boundary takes effect one period later
    run_to_pos(TOT - 1);
    cyc(1'b0, 1'b1, 18'd100);
    measure("coinc_old", 1000);
    measure("coinc_new", 400);

    // Clamp table
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 18'(tbl_val[i]));
      check("tbl_sat", int'(sat), tbl_sat[i]);
      run_to_pos(0);
      measure("tbl_hi", tbl_hi[i]);
    end

    // Timeout after eight missed boundaries, then recovery
    cyc(1'b0, 1'b1, 18'd250);
    run_to_pos(0);
    for (int i = 0; i < 7; i++) next_period();
    check("to_before", int'(fault), 0);
    next_period();
    check("to_fault", int'(fault), 1);
    check("to_pwm", int'(pwm), 0);
    run_to_pos(100);
    cyc(1'b0, 1'b1, 18'd50);
    check("fault_hold", int'(fault), 1);
    run_to_pos(0);
    check("fault_clear", int'(fault), 0);
    measure("recover_hi", 200);

    // Sample on the would-be timeout boundary keeps RUN
    for (int i = 0; i < 6; i++) next_period();
    run_to_pos(TOT - 1);
    cyc(1'b0, 1'b1, 18'd250);
    check("save_fault", int'(fault), 0);
    measure("save_hi", 200);

    // Mid-period reset
    run_to_pos(700);
    check("pre_rst_pwm", int'(pwm), 1);
    rst = 1'b1; ena2 = 1'b1; PWMin = 18'd300;
    #1;
    check("async_pwm", int'(pwm), 0);
    check("async_fault", int'(fault), 0);
    check("async_sat", int'(sat), 0);
    cyc(1'b1, 1'b1, 18'd300);
    cyc(1'b1, 1'b0, '0);
    n = 0;
    do begin
      cyc(1'b0, 1'b0, rnd());
      n++;
    end while (!period_tick && n < 3000);
    check("rst_tick_delay", n, TOT - 1);
    measure("idle_after_rst", 0);

    // Random samples
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 3))
        0: v = 18'($urandom_range(0, 499));
        1: v = 18'($urandom_range(498, 502));
        2: v = rnd();
        default: v = 18'($urandom_range(0, 520));
      endcase
      cyc(1'b0, ($urandom_range(0, 399) == 0), v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
